// File: rtl/controle_multiplicador_seq_if.sv
// Control bundle between the multiplier sequencer and its requester / shift-add datapath.
interface controle_multiplicador_seq_if #(
    parameter int CONT_W = 3
);
    logic              start;
    logic              cancelar;
    logic              bit_lsb;
    logic              ovf_parcial;
    logic              mult_restante_zero;
    logic              carregar_operandos;
    logic              limpar_acc;
    logic              somar;
    logic              deslocar;
    logic [CONT_W-1:0] iteracao;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, cancelar, bit_lsb, ovf_parcial, mult_restante_zero,
        input  carregar_operandos, limpar_acc, somar, deslocar,
               iteracao, busy, done, overflow
    );

    modport slave (
        input  start, cancelar, bit_lsb, ovf_parcial, mult_restante_zero,
        output carregar_operandos, limpar_acc, somar, deslocar,
               iteracao, busy, done, overflow
    );
endinterface

// File: rtl/controle_multiplicador_seq.sv
// Sequencer for the shift-add multiplier: start pulse -> LARGURA add/shift iterations -> done + sticky overflow.
// Optional MULT_EARLY_EXIT_EN: leave ITERA as soon as the remaining multiplier bits are all zero.
module controle_multiplicador_seq #(
    parameter int LARGURA = 8,
    parameter int CONT_W  = 3
) (
    input logic                         clk,
    input logic                         rst,
    controle_multiplicador_seq_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CARGA  = 2'd1,
        ITERA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

    localparam logic [CONT_W-1:0] ULTIMA = CONT_W'(LARGURA - 1);

    estado_t           estado, estado_nxt;
    logic [CONT_W-1:0] iter_q, iter_nxt;
    logic              ovf_q, ovf_nxt;
    logic              saida_antecipada;

`ifdef MULT_EARLY_EXIT_EN
    assign saida_antecipada = bus.mult_restante_zero;
`else
    assign saida_antecipada = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado <= OCIOSO;
            iter_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            estado <= estado_nxt;
            iter_q <= iter_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    always_comb begin
        estado_nxt             = estado;
        iter_nxt               = iter_q;
        ovf_nxt                = ovf_q;
        bus.carregar_operandos = 1'b0;
        bus.limpar_acc         = 1'b0;
        bus.somar              = 1'b0;
        bus.deslocar           = 1'b0;
        bus.busy               = 1'b0;
        bus.done               = 1'b0;

        case (estado)
            OCIOSO: begin
                if (bus.start && !bus.cancelar) estado_nxt = CARGA;
            end
            CARGA: begin
                bus.carregar_operandos = 1'b1;
                bus.limpar_acc         = 1'b1;
                bus.busy               = 1'b1;
                iter_nxt               = '0;
                ovf_nxt                = 1'b0;
                estado_nxt             = bus.cancelar ? OCIOSO : ITERA;
            end
            ITERA: begin
                bus.busy = 1'b1;
                if (bus.cancelar) begin
                    bus.deslocar = 1'b1;
                    bus.somar    = bus.bit_lsb;
                    iter_nxt     = '0;
                    ovf_nxt      = 1'b0;
                    estado_nxt   = OCIOSO;
                end else if (saida_antecipada) begin
                    // Nothing left to add: skip straight to FIM without touching the datapath.
                    ovf_nxt    = ovf_q | bus.ovf_parcial;
                    estado_nxt = FIM;
                end else begin
                    bus.deslocar = 1'b1;
                    bus.somar    = bus.bit_lsb;
                    ovf_nxt      = ovf_q | bus.ovf_parcial;
                    if (iter_q == ULTIMA) estado_nxt = FIM;
                    else                  iter_nxt   = iter_q + 1'b1;
                end
            end
            FIM: begin
                bus.done   = 1'b1;
                estado_nxt = OCIOSO;
            end
            default: estado_nxt = OCIOSO;
        endcase
    end

    assign bus.iteracao = iter_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_controle_multiplicador_seq.sv
// Directed bench for controle_multiplicador_seq (default LARGURA=8, CONT_W=3).
module tb_controle_multiplicador_seq;
    localparam int LARGURA = 8;
    localparam int CW      = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    controle_multiplicador_seq_if #(.CONT_W(CW)) bus ();

    controle_multiplicador_seq #(.LARGURA(LARGURA), .CONT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one start; drives bit_lsb/ovf_parcial/mult_restante_zero per ITERA cycle j = n-2.
    task automatic run_op(input logic [7:0] pat, input int ovf_it, input logic rz,
                          output int lat, output logic [7:0] som, output int desl,
                          output logic ovf_done, output logic [CW-1:0] it_done);
        int j;
        lat = -1; som = '0; desl = 0; ovf_done = 1'b0; it_done = '0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.cancelar = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            j = n - 2;
            if (j >= 0 && j < LARGURA) begin
                bus.bit_lsb            = pat[j];
                bus.ovf_parcial        = (j == ovf_it);
                bus.mult_restante_zero = rz && (j == 0);
            end else begin
                bus.bit_lsb            = 1'b0;
                bus.ovf_parcial        = 1'b0;
                bus.mult_restante_zero = 1'b0;
            end
            #1;
            if (j >= 0 && j < LARGURA && bus.somar) som[j] = 1'b1;
            if (bus.deslocar) desl++;
            if (bus.done) begin
                lat      = n;
                ovf_done = bus.overflow;
                it_done  = bus.iteracao;
                break;
            end
        end
        bus.bit_lsb            = 1'b0;
        bus.ovf_parcial        = 1'b0;
        bus.mult_restante_zero = 1'b0;
    endtask

    initial begin
        int          lat, desl, first_done, second_done, n_done, busy_low;
        logic [7:0]  som;
        logic        ovf_d;
        logic [CW-1:0] it_d;

        total = 0; bad = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.cancelar = 1'b0; bus.bit_lsb = 1'b0;
        bus.ovf_parcial = 1'b0; bus.mult_restante_zero = 1'b0;

        // Reset values
        @(negedge clk); #1;
        chk("rst_busy",     32'(bus.busy), 32'd0);
        chk("rst_done",     32'(bus.done), 32'd0);
        chk("rst_iteracao", 32'(bus.iteracao), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_ctrl", 32'({bus.carregar_operandos, bus.limpar_acc, bus.somar, bus.deslocar}), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // 5x3: multiplier 3 -> LSB stream 1,1,0,0,0,0,0,0
        run_op(8'h03, -1, 1'b0, lat, som, desl, ovf_d, it_d);
        chk("5x3_latency",  32'(lat), 32'd10);
        chk("5x3_somar",    32'(som), 32'h03);
        chk("5x3_deslocar", 32'(desl), 32'd8);
        chk("5x3_overflow", 32'(ovf_d), 32'd0);
        chk("5x3_iter_fim", 32'(it_d), 32'd7);

        // 20x20 with a carry lost in iteration 6
        run_op(8'h14, 6, 1'b0, lat, som, desl, ovf_d, it_d);
        chk("20x20_latency",  32'(lat), 32'd10);
        chk("20x20_somar",    32'(som), 32'h14);
        chk("20x20_overflow", 32'(ovf_d), 32'd1);
        repeat (3) @(negedge clk);
        #1 chk("ovf_held_idle", 32'(bus.overflow), 32'd1);

        // Next operation clears the sticky flag in CARGA
        run_op(8'h81, -1, 1'b0, lat, som, desl, ovf_d, it_d);
        chk("clear_latency",  32'(lat), 32'd10);
        chk("clear_somar",    32'(som), 32'h81);
        chk("clear_overflow", 32'(ovf_d), 32'd0);

        // Cancel at iteracao=3 after accumulating an overflow
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            bus.ovf_parcial = (n == 3);
            if (n == 5) begin
                #1;
                chk("cancel_iter3", 32'(bus.iteracao), 32'd3);
                chk("cancel_ovf_pre", 32'(bus.overflow), 32'd1);
                bus.cancelar = 1'b1;
            end
            if (n == 6) begin
                bus.cancelar = 1'b0;
                #1;
                chk("cancel_idle", 32'({bus.busy, bus.done}), 32'd0);
                chk("cancel_iter", 32'(bus.iteracao), 32'd0);
                chk("cancel_ovf",  32'(bus.overflow), 32'd0);
            end
        end
        run_op(8'h05, -1, 1'b0, lat, som, desl, ovf_d, it_d);
        chk("after_cancel_latency", 32'(lat), 32'd10);

        // start held high for 30 cycles
        @(negedge clk);
        bus.start = 1'b1;
        first_done = -1; second_done = -1; n_done = 0; busy_low = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk); #1;
            if (bus.done) begin
                n_done++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
            if (!bus.busy) busy_low++;
        end
        chk("held_done_count", 32'(n_done), 32'd2);
        chk("held_done_1",     32'(first_done), 32'd10);
        chk("held_done_2",     32'(second_done), 32'd21);
        chk("held_busy_low",   32'(busy_low), 32'd4);
        bus.start = 1'b0;
        @(negedge clk); bus.cancelar = 1'b1;
        @(negedge clk); bus.cancelar = 1'b0;
        @(negedge clk);

        // Multiplier = 0 with mult_restante_zero in the first ITERA
        run_op(8'h00, -1, 1'b1, lat, som, desl, ovf_d, it_d);
`ifdef MULT_EARLY_EXIT_EN
        chk("zero_latency",  32'(lat), 32'd3);
        chk("zero_deslocar", 32'(desl), 32'd0);
`else
        chk("zero_latency",  32'(lat), 32'd10);
        chk("zero_deslocar", 32'(desl), 32'd8);
`endif

        // Asynchronous reset in the middle of ITERA (iteracao=4)
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            bus.bit_lsb = 1'b1;
        end
        #1;
        chk("mid_iter4", 32'(bus.iteracao), 32'd4);
        chk("mid_busy",  32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_outputs", 32'({bus.carregar_operandos, bus.limpar_acc, bus.somar,
                                  bus.deslocar, bus.busy, bus.done, bus.overflow}), 32'd0);
        chk("async_iter", 32'(bus.iteracao), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.bit_lsb = 1'b0;
        n_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk); #1;
            if (bus.done || bus.busy) n_done++;
        end
        chk("post_reset_quiet", 32'(n_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
